// File: rtl/booth_radix4_multiplier_if.sv
// Operand/handshake bundle for the radix-4 Booth multiplier.
// The master drives the operands and start; the slave returns busy, ready and Result.
interface booth_radix4_multiplier_if #(
  parameter int unsigned WORD_LENGTH = 8
);
  logic                       start;
  logic                       Sign;
  logic [WORD_LENGTH-1:0]     Multiplicand;
  logic [WORD_LENGTH-1:0]     Multiplier;
  logic                       busy;
  logic                       ready;
  logic [2*WORD_LENGTH-1:0]   Result;

  modport master (
    output start, Sign, Multiplicand, Multiplier,
    input  busy, ready, Result
  );

  modport slave (
    input  start, Sign, Multiplicand, Multiplier,
    output busy, ready, Result
  );
endinterface

// File: rtl/booth_radix4_multiplier.sv
// Sequential modified-Booth (radix-4) multiplier, WORD_LENGTH x WORD_LENGTH -> 2*WORD_LENGTH,
// signed or unsigned per operation, start/ready handshake, one operation in flight.
module booth_radix4_multiplier #(
  parameter int unsigned WORD_LENGTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  booth_radix4_multiplier_if.slave  bus
);

  localparam int unsigned WL   = WORD_LENGTH;
  localparam int unsigned ITER = WL / 2 + 1;
  localparam int unsigned XW   = WL + 2;        // extended operand width
  localparam int unsigned HW   = WL + 4;        // high half, holds running sum plus +-2A headroom
  localparam int unsigned LW   = XW + 1;        // multiplier field plus appended Booth bit
  localparam int unsigned AW   = HW + LW;
  localparam int unsigned PW   = 2 * WL;
  localparam int unsigned CW   = $clog2(ITER + 1);

  if ((WL % 2) != 0 || WL < 4 || WL > 32) begin : g_bad_width
    $error("booth_radix4_multiplier: WORD_LENGTH must be even and within 4..32");
  end

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t          state;
  logic [HW-1:0]   a_ext;
  logic [AW-1:0]   acc;
  logic [CW-1:0]   count;
  logic            busy;
  logic            ready;
  logic [PW-1:0]   result;

  logic [HW-1:0]   a_load;
  logic [XW-1:0]   b_load;
  logic [HW-1:0]   pp;
  logic [HW-1:0]   hi_sum;
  logic [AW-1:0]   acc_next;

  // Operand extension, Booth recode of the 3 LSBs, add into the high half, arithmetic shift by 2.
  always_comb begin
    a_load = '0;
    b_load = '0;
    if (bus.Sign) begin
      a_load = HW'($signed(bus.Multiplicand));
      b_load = XW'($signed(bus.Multiplier));
    end else begin
      a_load = HW'(bus.Multiplicand);
      b_load = XW'(bus.Multiplier);
    end

    pp = '0;
    case (acc[2:0])
      3'b001, 3'b010: pp = a_ext;
      3'b011:         pp = HW'(a_ext << 1);
      3'b100:         pp = HW'(-(a_ext << 1));
      3'b101, 3'b110: pp = HW'(-a_ext);
      default:        pp = '0;
    endcase

    hi_sum   = acc[AW-1:LW] + pp;
    acc_next = AW'($signed({hi_sum, acc[LW-1:0]}) >>> 2);
  end

  // Control FSM with registered handshake outputs; start is only honoured outside CALC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      a_ext  <= '0;
      acc    <= '0;
      count  <= '0;
      busy   <= 1'b0;
      ready  <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          ready <= 1'b0;
          if (bus.start) begin
            a_ext <= a_load;
            acc   <= {HW'(0), b_load, 1'b0};
            count <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          acc   <= acc_next;
          count <= count + CW'(1);
          if (count == CW'(ITER - 1)) begin
            // Product sits one bit above the appended Booth bit after the final shift.
            result <= acc_next[PW:1];
            ready  <= 1'b1;
            busy   <= 1'b0;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy;
  assign bus.ready  = ready;
  assign bus.Result = result;

endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// Self-checking bench for booth_radix4_multiplier (WORD_LENGTH=8): directed vector table,
// handshake corner sequences and randomized operations against an arithmetic reference.
module tb_booth_radix4_multiplier;

  localparam int unsigned WL = 8;

  typedef struct {
    bit          s;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  booth_radix4_multiplier_if #(.WORD_LENGTH(WL)) bus ();

  booth_radix4_multiplier #(.WORD_LENGTH(WL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference product from plain integer arithmetic on the interpreted operand values.
  function automatic logic [15:0] ref_mul(input bit s, input logic [7:0] a, input logic [7:0] b);
    int va;
    int vb;
    va = s ? int'($signed(a)) : int'(a);
    vb = s ? int'($signed(b)) : int'(b);
    return 16'(va * vb);
  endfunction

  function automatic logic [7:0] pick();
    case ($urandom_range(0, 7))
      0: return 8'h00;
      1: return 8'h01;
      2: return 8'hFF;
      3: return 8'h7F;
      4: return 8'h80;
      default: return 8'($urandom);
    endcase
  endfunction

  // One operation from IDLE: lat counts negedges from the one after the accept edge to ready.
  task automatic do_op(input bit s, input logic [7:0] a, input logic [7:0] b,
                       output logic [15:0] res, output int lat, output int bcyc,
                       output logic rdy_after);
    @(negedge clk);
    bus.start = 1'b1;
    bus.Sign = s;
    bus.Multiplicand = a;
    bus.Multiplier = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.Sign = ~s;
    bus.Multiplicand = 8'($urandom);
    bus.Multiplier = 8'($urandom);
    lat = 0;
    bcyc = 0;
    while (!bus.ready && lat < 40) begin
      if (bus.busy) bcyc++;
      @(negedge clk);
      lat++;
    end
    res = bus.Result;
    @(negedge clk);
    rdy_after = bus.ready;
  endtask

  initial begin
    vec_t        vec [12];
    logic [15:0] res;
    int          lat;
    int          bcyc;
    logic        rdy2;
    int          pulses;
    int          t_rdy [2];
    logic [15:0] r_rdy [2];

    vec[0]  = '{1'b0, 8'h03, 8'h04, 16'h000C};
    vec[1]  = '{1'b1, 8'hFD, 8'h04, 16'hFFF4};
    vec[2]  = '{1'b0, 8'hFD, 8'h04, 16'h03F4};
    vec[3]  = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
    vec[4]  = '{1'b1, 8'h80, 8'h80, 16'h4000};
    vec[5]  = '{1'b1, 8'h7F, 8'h80, 16'hC080};
    vec[6]  = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
    vec[7]  = '{1'b1, 8'hFF, 8'h01, 16'hFFFF};
    vec[8]  = '{1'b0, 8'h00, 8'hFF, 16'h0000};
    vec[9]  = '{1'b1, 8'h7F, 8'h7F, 16'h3F01};
    vec[10] = '{1'b0, 8'h80, 8'h80, 16'h4000};
    vec[11] = '{1'b1, 8'h80, 8'h01, 16'hFF80};

    checks = 0;
    failures = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.Sign = 1'b0;
    bus.Multiplicand = '0;
    bus.Multiplier = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_ready", 32'(bus.ready), 32'd0);
    check("reset_result", 32'(bus.Result), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      do_op(vec[i].s, vec[i].a, vec[i].b, res, lat, bcyc, rdy2);
      check($sformatf("vec%0d_result", i), 32'(res), 32'(vec[i].exp));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd5);
      check($sformatf("vec%0d_busy_cycles", i), 32'(bcyc), 32'd5);
      check($sformatf("vec%0d_ready_width", i), 32'(rdy2), 32'd0);
    end

    // start pulses and operand changes while busy must not disturb the 5*6 in flight
    @(negedge clk);
    bus.start = 1'b1;
    bus.Sign = 1'b0;
    bus.Multiplicand = 8'd5;
    bus.Multiplier = 8'd6;
    pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.ready) begin
        pulses++;
        res = bus.Result;
      end
      bus.start = (i == 1 || i == 3);
      bus.Multiplicand = 8'd9;
      bus.Multiplier = 8'd9;
    end
    check("busy_ignore_pulses", 32'(pulses), 32'd1);
    check("busy_ignore_result", 32'(res), 32'h001E);
    check("busy_ignore_hold", 32'(bus.Result), 32'h001E);

    // start held high: back-to-back 2*3 then 7*7
    @(negedge clk);
    bus.start = 1'b1;
    bus.Multiplicand = 8'd2;
    bus.Multiplier = 8'd3;
    pulses = 0;
    t_rdy[0] = 0;
    t_rdy[1] = 0;
    r_rdy[0] = '0;
    r_rdy[1] = '0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (bus.ready) begin
        if (pulses < 2) begin
          t_rdy[pulses] = i;
          r_rdy[pulses] = bus.Result;
        end
        pulses++;
      end
      if (i == 1) begin
        bus.Multiplicand = 8'd7;
        bus.Multiplier = 8'd7;
      end
      if (i == 7) bus.start = 1'b0;
    end
    check("b2b_pulses", 32'(pulses), 32'd2);
    check("b2b_first_latency", 32'(t_rdy[0]), 32'd6);
    check("b2b_spacing", 32'(t_rdy[1] - t_rdy[0]), 32'd6);
    check("b2b_first_result", 32'(r_rdy[0]), 32'h0006);
    check("b2b_second_result", 32'(r_rdy[1]), 32'h0031);

    // reset two cycles into CALC, asserted between clock edges
    @(negedge clk);
    bus.start = 1'b1;
    bus.Multiplicand = 8'd3;
    bus.Multiplier = 8'd3;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midreset_busy", 32'(bus.busy), 32'd0);
    check("midreset_ready", 32'(bus.ready), 32'd0);
    check("midreset_result", 32'(bus.Result), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.ready) pulses++;
    end
    check("midreset_no_ready", 32'(pulses), 32'd0);
    check("midreset_result_held", 32'(bus.Result), 32'd0);
    do_op(1'b0, 8'd10, 8'd10, res, lat, bcyc, rdy2);
    check("after_reset_result", 32'(res), 32'h0064);
    check("after_reset_latency", 32'(lat), 32'd5);

    // randomized operations in both modes, biased towards 0, 1, -1, min and max
    for (int i = 0; i < 3000; i++) begin
      bit          s;
      logic [7:0]  a;
      logic [7:0]  b;
      s = 1'($urandom);
      a = pick();
      b = pick();
      do_op(s, a, b, res, lat, bcyc, rdy2);
      check($sformatf("rand%0d_s%0d_%02h_x_%02h", i, s, a, b), 32'(res), 32'(ref_mul(s, a, b)));
      check($sformatf("rand%0d_latency", i), 32'(lat), 32'd5);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
